store_narrower: RTL
===================

Name: store_narrower

Overview:
- Store-path mirror of the load extender: takes a full 32-bit register value, truncates it to byte, half or word, lane-aligns it, and drives word-aligned memory write beats with byte enables.
- Sits between the execute/MEM stage store request and the data-memory write port.
- Stores that cross a word boundary are split into two beats.
- A one-cycle completion or fault pulse is returned to the pipeline.

Parameters:
- DATA_WIDTH, 32: register and memory word width. Only 32 is supported; an elaboration assertion enforces this.
- ADDR_WIDTH, 32: byte address width.

Ports:
- i_CLK  in  1  clock; all state changes on the rising edge.
- i_RST  in  1  reset; asynchronous, active-high.
- i_ReqValid  in  1  store request valid.
- o_ReqReady  out  1  block can accept a request.
- i_Address  in  ADDR_WIDTH  byte address.
- i_Data  in  DATA_WIDTH  register value; only the low 8/16/32 bits are used.
- i_Size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- o_MemValid  out  1  write beat valid.
- i_MemReady  in  1  memory accepts the beat.
- o_MemAddress  out  ADDR_WIDTH  word-aligned beat address (bits [1:0] = 0).
- o_MemData  out  DATA_WIDTH  lane-aligned write data.
- o_MemByteEnable  out  4  per-byte write enable; bit k covers o_MemData[8k+7:8k].
- o_Done  out  1  one-cycle pulse, store complete.
- o_Fault  out  1  one-cycle pulse, store rejected; no memory write occurred.

Behaviour:
- Reset:
  - Asynchronous, active-high; FSM goes to S_IDLE.
  - All registered outputs clear to 0: o_MemValid, o_MemAddress, o_MemData, o_MemByteEnable, o_Done, o_Fault.
  - o_ReqReady is 0 while i_RST is high.
  - Reset mid-transfer abandons any pending beat; a split store may be left half-written.
- States: S_IDLE, S_BEAT0, S_BEAT1.
- Accept:
  - o_ReqReady = 1 only in S_IDLE (and i_RST low).
  - Handshake at cycle t latches address, data and size.
- Lane computation (registered at accept):
  - offset = addr[1:0]; nbytes = 1, 2 or 4.
  - 8-bit mask = ((1<<nbytes)-1) << offset.
  - 64-bit data = zero-extended truncated value << (8*offset).
  - Beat0 gets mask[3:0] and data[31:0]; beat1 gets mask[7:4] and data[63:32].
  - Bytes that are not enabled drive 0.
- Beat addresses:
  - Beat0 address = {addr[AW-1:2], 2'b00}.
  - Beat1 address = beat0 address + 4, modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0x00000000.
- Transitions:
  - From S_IDLE: valid request goes to S_BEAT0, with o_MemValid = 1 at t+1.
  - From S_BEAT0: on i_MemReady, go to S_BEAT1 if mask[7:4] != 0, else go to S_IDLE.
  - From S_BEAT1: on i_MemReady, go to S_IDLE.
- Beat stability: o_MemValid and all beat fields hold stable until i_MemReady is sampled high. Back-to-back beats do not deassert o_MemValid between them.
- o_Done:
  - Pulses exactly once, in the cycle after the final memory handshake.
  - The FSM is already in S_IDLE in that cycle, so a new request may be accepted in the same cycle as o_Done.
- Reserved size (11): the request is accepted, no beat is issued, o_Fault pulses at t+1, and the FSM stays in S_IDLE.
- o_Done and o_Fault are never high together.
- Single-request latency with memory always ready: accept at t; beat0 at t+1; done at t+2 (aligned) or t+3 (split).

Optional Feature:
- Macro: HAZE_STORE_MISALIGN_TRAP_EN.
- Defined: any request with mask[7:4] != 0 (crosses a word boundary) is rejected. No beat is issued, o_Fault pulses at t+1, and S_BEAT1 is unreachable; it may be optimised out.
- Undefined: crossing stores are split into two beats as above, and o_Fault fires only for the reserved size.

Decomposition:
- Package haze_mem_pkg:
  - mem_size_t enum {SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_RSVD=2'b11}.
  - store_state_t enum {S_IDLE, S_BEAT0, S_BEAT1}.
  - Constant BYTES_PER_WORD = 4.
- Sub-module store_lane_aligner:
  - Purely combinational.
  - Inputs: offset, size, data. Outputs: 8-bit mask and 64-bit shifted data.
  - Unit-testable on its own and reusable by a future cache fill path.

Test Plan:
- Byte store, addr 0x1003, data 0xDEADBEEF, memory always ready:
  - One beat: addr 0x1000, BE 4'b1000, data 0xEF000000.
  - o_Done at t+2.
- Half store, addr 0x2002, data 0x12345678:
  - One beat: addr 0x2000, BE 4'b1100, data 0x56780000.
- Word store, addr 0x3002, data 0xAABBCCDD, macro undefined:
  - Beat0: addr 0x3000, BE 4'b1100, data 0xCCDD0000.
  - Beat1: addr 0x3004, BE 4'b0011, data 0x0000AABB.
  - o_Done at t+3.
  - With the macro defined instead: no beats, o_Fault at t+1.
- Backpressure: i_MemReady low for 3 cycles during beat0 of a word store to 0x4000:
  - Beat fields held stable.
  - o_ReqReady stays 0.
  - o_Done follows the cycle after ready.
- Wrap and reserved size:
  - Half store to 0xFFFFFFFF (macro undefined): beat0 at 0xFFFFFFFC with BE 1000, beat1 at 0x00000000 with BE 0001.
  - Size 2'b11: o_Fault only, no o_MemValid.
- Reset during beat1 of a split store:
  - All outputs 0 immediately.
  - After release, o_ReqReady = 1 and no o_Done is produced.

Source files
------------

// File: rtl/haze_mem_pkg.sv
// Shared memory-path types for the store narrower and related load/store blocks.
package haze_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BEAT0 = 2'b01,
    S_BEAT1 = 2'b10
  } store_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/store_lane_aligner.sv
// Combinational truncate-and-shift of a store value into an 8-byte (two-word) lane window.
module store_lane_aligner
  import haze_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [7:0]  mask,
  output logic [63:0] data_out
);

  logic [7:0]  base_mask;
  logic [63:0] trunc;
  logic [63:0] shifted;

  always_comb begin
    base_mask = 8'h00;
    trunc     = 64'h0;
    case (mem_size_t'(size))
      SIZE_BYTE: begin
        base_mask = 8'h01;
        trunc     = {56'h0, data[7:0]};
      end
      SIZE_HALF: begin
        base_mask = 8'h03;
        trunc     = {48'h0, data[15:0]};
      end
      SIZE_WORD: begin
        base_mask = 8'h0F;
        trunc     = {32'h0, data};
      end
      default: begin
        base_mask = 8'h00;
        trunc     = 64'h0;
      end
    endcase
  end

  assign mask    = base_mask << offset;
  assign shifted = trunc << {offset, 3'b000};

  // Disabled lanes are forced to zero so memory never sees stale register bits.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign data_out[8*gi +: 8] = mask[gi] ? shifted[8*gi +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/store_narrower.sv
// Store-path narrower: truncates, lane-aligns and splits stores into word write beats.
// Optional: HAZE_STORE_MISALIGN_TRAP_EN rejects word-crossing stores with o_Fault.
module store_narrower
  import haze_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_ReqValid,
  output logic                  o_ReqReady,
  input  logic [ADDR_WIDTH-1:0] i_Address,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic [1:0]            i_Size,
  output logic                  o_MemValid,
  input  logic                  i_MemReady,
  output logic [ADDR_WIDTH-1:0] o_MemAddress,
  output logic [DATA_WIDTH-1:0] o_MemData,
  output logic [3:0]            o_MemByteEnable,
  output logic                  o_Done,
  output logic                  o_Fault
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("store_narrower supports DATA_WIDTH = 32 only");
  end

  store_state_t          state;
  logic [3:0]            hi_mask;
  logic [DATA_WIDTH-1:0] hi_data;

  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic        accept;
  logic        crosses;
  logic        reject;

  store_lane_aligner u_aligner (
    .offset   (i_Address[1:0]),
    .size     (i_Size),
    .data     (i_Data),
    .mask     (lane_mask),
    .data_out (lane_data)
  );

  assign o_ReqReady = (state == S_IDLE) && !i_RST;
  assign accept     = i_ReqValid && o_ReqReady;
  assign crosses    = |lane_mask[7:4];

`ifdef HAZE_STORE_MISALIGN_TRAP_EN
  assign reject = (mem_size_t'(i_Size) == SIZE_RSVD) || crosses;
`else
  assign reject = (mem_size_t'(i_Size) == SIZE_RSVD);
`endif

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state           <= S_IDLE;
      o_MemValid      <= 1'b0;
      o_MemAddress    <= '0;
      o_MemData       <= '0;
      o_MemByteEnable <= 4'h0;
      o_Done          <= 1'b0;
      o_Fault         <= 1'b0;
      hi_mask         <= 4'h0;
      hi_data         <= '0;
    end else begin
      o_Done  <= 1'b0;
      o_Fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (reject) begin
              o_Fault <= 1'b1;
            end else begin
              state           <= S_BEAT0;
              o_MemValid      <= 1'b1;
              o_MemAddress    <= {i_Address[ADDR_WIDTH-1:2], 2'b00};
              o_MemData       <= lane_data[31:0];
              o_MemByteEnable <= lane_mask[3:0];
              hi_mask         <= crosses ? lane_mask[7:4] : 4'h0;
              hi_data         <= lane_data[63:32];
            end
          end
        end
        S_BEAT0: begin
          if (i_MemReady) begin
            if (hi_mask != 4'h0) begin
              // Keep o_MemValid high: the second beat follows with no bubble.
              state           <= S_BEAT1;
              o_MemAddress    <= o_MemAddress + ADDR_WIDTH'(BYTES_PER_WORD);
              o_MemData       <= hi_data;
              o_MemByteEnable <= hi_mask;
            end else begin
              state           <= S_IDLE;
              o_MemValid      <= 1'b0;
              o_MemAddress    <= '0;
              o_MemData       <= '0;
              o_MemByteEnable <= 4'h0;
              o_Done          <= 1'b1;
            end
          end
        end
        S_BEAT1: begin
          if (i_MemReady) begin
            state           <= S_IDLE;
            o_MemValid      <= 1'b0;
            o_MemAddress    <= '0;
            o_MemData       <= '0;
            o_MemByteEnable <= 4'h0;
            o_Done          <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          o_MemValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
